icache_refill_ctrl: RTL and testbench

Parametrised instruction-cache refill controller for the multithreaded RISC-V core. It sits between the fetch-stage cache lookup and the instruction RAM port. It holds one pending miss per hart and arbitrates them round-robin onto a single outstanding RAM read. Each returned word is written back into the direct-mapped cache, and the owning hart gets a completion notification; per-hart flush cancels stale requests.

---
 rtl/icache_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/icache_refill_ctrl.sv | 134 +++++++++++++
 tb/tb_icache_refill_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-slicing helpers for the instruction-cache refill path.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, FILL} refill_state_e;

  function automatic int hart_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] index_slice(input logic [63:0] addr, input int index_w);
    return (addr >> 2) & ((64'd1 << index_w) - 64'd1);
  endfunction

  function automatic logic [63:0] tag_slice(input logic [63:0] addr, input int index_w,
                                            input int tag_w);
    return (addr >> (index_w + 2)) & ((64'd1 << tag_w) - 64'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant and wraps modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);
  localparam int IW = $clog2(N);
  localparam int CW = IW + 1;

  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = {1'b0, last_q} + CW'(i);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      if (!gnt_any && req[cand[IW-1:0]]) begin
        gnt_any              = 1'b1;
        gnt[cand[IW-1:0]]    = 1'b1;
        gnt_idx              = cand[IW-1:0];
      end
    end
    last_d = (advance && gnt_any) ? gnt_idx : last_q;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) last_q <= IW'(N - 1);
    else         last_q <= last_d;
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache refill controller: one pending miss per hart, round-robin onto a single RAM read.
//   state | meaning
//   IDLE  | no read outstanding
//   WAIT  | ram_req held for cur_addr until ram_ready
//   FILL  | write captured word into cache, notify hart, pick next
module icache_refill_ctrl import icache_pkg::*; #(
  parameter int NUM_HARTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int INDEX_W   = 7,
  parameter int TAG_W     = 7
) (
  input  logic                         clk,
  input  logic                         nReset,
  input  logic                         miss_valid,
  input  logic [hart_w(NUM_HARTS)-1:0] miss_hart,
  input  logic [ADDR_W-1:0]            miss_addr,
  input  logic [NUM_HARTS-1:0]         flush,
  output logic                         ram_req,
  output logic [ADDR_W-1:0]            ram_addr,
  input  logic                         ram_ready,
  input  logic [DATA_W-1:0]            ram_data,
  output logic                         fill_we,
  output logic [INDEX_W-1:0]           fill_index,
  output logic [TAG_W-1:0]             fill_tag,
  output logic [DATA_W-1:0]            fill_data,
  output logic                         done_valid,
  output logic [hart_w(NUM_HARTS)-1:0] done_hart,
  output logic [DATA_W-1:0]            done_data,
  output logic [NUM_HARTS-1:0]         pending,
  output logic                         busy
);
  localparam int HW = hart_w(NUM_HARTS);

  refill_state_e        state_q, state_d;
  logic [NUM_HARTS-1:0] pend_v_q, pend_v_d, pend_nx;
  logic [ADDR_W-1:0]    pend_addr_q [NUM_HARTS];
  logic [ADDR_W-1:0]    pend_addr_d [NUM_HARTS];
  logic [HW-1:0]        cur_hart_q, cur_hart_d;
  logic [ADDR_W-1:0]    cur_addr_q, cur_addr_d;
  logic                 cur_cancel_q, cur_cancel_d;
  logic [DATA_W-1:0]    data_q, data_d;

  logic                 busy_w, miss_take, grant_en, gnt_any;
  logic [NUM_HARTS-1:0] arb_req, gnt_oh;
  logic [HW-1:0]        gnt_idx;

  // Incoming miss is folded into the table first so it can be granted the same cycle.
  always_comb begin
    busy_w      = (state_q != IDLE);
    miss_take   = miss_valid && ({1'b0, miss_hart} < (HW + 1)'(NUM_HARTS)) &&
                  !(busy_w && miss_hart == cur_hart_q && miss_addr == cur_addr_q);
    pend_nx     = pend_v_q & ~flush;
    pend_addr_d = pend_addr_q;
    if (miss_take) begin
      pend_nx[miss_hart]     = 1'b1;
      pend_addr_d[miss_hart] = miss_addr;
    end
    grant_en = (state_q == IDLE) || (state_q == FILL);
    arb_req  = grant_en ? pend_nx : '0;
  end

  rr_arbiter #(.N(NUM_HARTS)) u_arb (
    .clk     (clk),
    .nReset  (nReset),
    .req     (arb_req),
    .advance (gnt_any),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    state_d      = state_q;
    pend_v_d     = pend_nx;
    cur_hart_d   = cur_hart_q;
    cur_addr_d   = cur_addr_q;
    data_d       = data_q;
    cur_cancel_d = cur_cancel_q | (busy_w & flush[cur_hart_q]);
    case (state_q)
      IDLE: state_d = IDLE;
      WAIT: begin
        if (ram_ready) begin
          data_d  = ram_data;
          state_d = FILL;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (gnt_any) begin
      state_d      = WAIT;
      pend_v_d     = pend_nx & ~gnt_oh;
      cur_hart_d   = gnt_idx;
      cur_addr_d   = pend_addr_d[gnt_idx];
      cur_cancel_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= IDLE;
      pend_v_q     <= '0;
      for (int h = 0; h < NUM_HARTS; h++) pend_addr_q[h] <= '0;
      cur_hart_q   <= '0;
      cur_addr_q   <= '0;
      cur_cancel_q <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      pend_v_q     <= pend_v_d;
      pend_addr_q  <= pend_addr_d;
      cur_hart_q   <= cur_hart_d;
      cur_addr_q   <= cur_addr_d;
      cur_cancel_q <= cur_cancel_d;
      data_q       <= data_d;
    end
  end

  // A cancelled transfer no longer counts as pending for its hart.
  assign pending    = pend_v_q |
                      ((busy_w && !cur_cancel_q) ? (NUM_HARTS'(1) << cur_hart_q) : '0);
  assign busy       = busy_w;
  assign ram_req    = (state_q == WAIT);
  assign ram_addr   = cur_addr_q;
  assign fill_we    = (state_q == FILL);
  assign fill_index = INDEX_W'(index_slice(64'(cur_addr_q), INDEX_W));
  assign fill_tag   = TAG_W'(tag_slice(64'(cur_addr_q), INDEX_W, TAG_W));
  assign fill_data  = data_q;
  assign done_valid = fill_we && !cur_cancel_q;
  assign done_hart  = cur_hart_q;
  assign done_data  = data_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: 4-hart instance plus a 3-hart instance for wrap-around.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        miss_valid = 1'b0;
  logic [1:0]  miss_hart = '0;
  logic [31:0] miss_addr = '0;
  logic [3:0]  flush = '0;
  logic        ram_ready = 1'b0;
  logic [31:0] ram_data = '0;

  logic        ram_req, fill_we, done_valid, busy;
  logic [31:0] ram_addr, fill_data, done_data;
  logic [6:0]  fill_index, fill_tag;
  logic [1:0]  done_hart;
  logic [3:0]  pending;

  logic        b_ram_req, b_fill_we, b_done_valid, b_busy;
  logic [31:0] b_ram_addr, b_fill_data, b_done_data;
  logic [6:0]  b_fill_index, b_fill_tag;
  logic [1:0]  b_done_hart;
  logic [2:0]  b_pending;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  icache_refill_ctrl #(.NUM_HARTS(4)) dut (
    .clk(clk), .nReset(nReset), .miss_valid(miss_valid), .miss_hart(miss_hart),
    .miss_addr(miss_addr), .flush(flush), .ram_req(ram_req), .ram_addr(ram_addr),
    .ram_ready(ram_ready), .ram_data(ram_data), .fill_we(fill_we), .fill_index(fill_index),
    .fill_tag(fill_tag), .fill_data(fill_data), .done_valid(done_valid), .done_hart(done_hart),
    .done_data(done_data), .pending(pending), .busy(busy)
  );

  icache_refill_ctrl #(.NUM_HARTS(3)) dut3 (
    .clk(clk), .nReset(nReset), .miss_valid(miss_valid), .miss_hart(miss_hart),
    .miss_addr(miss_addr), .flush(flush[2:0]), .ram_req(b_ram_req), .ram_addr(b_ram_addr),
    .ram_ready(ram_ready), .ram_data(ram_data), .fill_we(b_fill_we), .fill_index(b_fill_index),
    .fill_tag(b_fill_tag), .fill_data(b_fill_data), .done_valid(b_done_valid),
    .done_hart(b_done_hart), .done_data(b_done_data), .pending(b_pending), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    miss_valid = 1'b0;
    miss_hart  = '0;
    miss_addr  = '0;
    flush      = '0;
    ram_ready  = 1'b0;
    ram_data   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nReset = 1'b0;
    tick();
    tick();
    nReset = 1'b1;
  endtask

  task automatic miss(input logic [1:0] h, input logic [31:0] a);
    miss_valid = 1'b1;
    miss_hart  = h;
    miss_addr  = a;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ram_req !== 1'b0) begin failures++; $display("FAIL reset_ram_req got=%0b exp=0", ram_req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (pending !== 4'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0000", pending); end
    checks++; if ({fill_we, done_valid} !== 2'b00) begin failures++; $display("FAIL reset_fill_done got=%b exp=00", {fill_we, done_valid}); end
    checks++; if (ram_addr !== 32'h0) begin failures++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
    do_reset();
  endtask

  task automatic test_single_miss();
    do_reset();
    miss(2'd0, 32'h0000_0A04);
    tick();
    clear_inputs();
    checks++; if (ram_req !== 1'b1 || ram_addr !== 32'h0000_0A04) begin failures++; $display("FAIL single_req got req=%0b addr=%h exp req=1 addr=00000a04", ram_req, ram_addr); end
    checks++; if (pending !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL single_pending got=%b busy=%0b exp=0001 busy=1", pending, busy); end
    tick();
    tick();
    checks++; if (ram_req !== 1'b1 || ram_addr !== 32'h0000_0A04) begin failures++; $display("FAIL single_hold got req=%0b addr=%h exp req=1 addr=00000a04", ram_req, ram_addr); end
    ram_ready = 1'b1;
    ram_data  = 32'h1234_5678;
    tick();
    clear_inputs();
    checks++; if (fill_we !== 1'b1 || ram_req !== 1'b0) begin failures++; $display("FAIL single_fill got we=%0b req=%0b exp we=1 req=0", fill_we, ram_req); end
    checks++; if (fill_index !== 7'h01 || fill_tag !== 7'h05) begin failures++; $display("FAIL single_slice got idx=%h tag=%h exp idx=01 tag=05", fill_index, fill_tag); end
    checks++; if (done_valid !== 1'b1 || done_hart !== 2'd0 || done_data !== 32'h1234_5678 || fill_data !== 32'h1234_5678) begin failures++; $display("FAIL single_done got v=%0b h=%0d d=%h f=%h exp v=1 h=0 d=12345678", done_valid, done_hart, done_data, fill_data); end
    tick();
    checks++; if (busy !== 1'b0 || fill_we !== 1'b0 || pending !== 4'b0) begin failures++; $display("FAIL single_idle got busy=%0b we=%0b pend=%b exp 0 0 0000", busy, fill_we, pending); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_h [3];
    logic [31:0] exp_a [3];
    do_reset();
    miss(2'd0, 32'h1000); tick();
    miss(2'd1, 32'h1100); tick();
    miss(2'd2, 32'h1200); tick();
    miss(2'd3, 32'h1300); tick();
    clear_inputs();
    checks++; if (pending !== 4'b1111) begin failures++; $display("FAIL rr_pending got=%b exp=1111", pending); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (ram_req !== 1'b1 || ram_addr !== 32'h1000 + 32'(k) * 32'h100) begin failures++; $display("FAIL rr_req%0d got req=%0b addr=%h exp addr=%h", k, ram_req, ram_addr, 32'h1000 + 32'(k) * 32'h100); end
      ram_ready = 1'b1; tick(); ram_ready = 1'b0;
      checks++; if (done_valid !== 1'b1 || done_hart !== 2'(k)) begin failures++; $display("FAIL rr_done%0d got v=%0b h=%0d exp h=%0d", k, done_valid, done_hart, k); end
      tick();
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle got busy=%0b exp=0", busy); end
    // pointer is now 3: grant 2 first, then 3 ahead of 1
    exp_h = '{2'd2, 2'd3, 2'd1};
    exp_a = '{32'h2200, 32'h2300, 32'h2100};
    miss(2'd2, 32'h2200); tick();
    miss(2'd1, 32'h2100); tick();
    miss(2'd3, 32'h2300); tick();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      checks++; if (ram_req !== 1'b1 || ram_addr !== exp_a[k]) begin failures++; $display("FAIL rr_rot_req%0d got req=%0b addr=%h exp addr=%h", k, ram_req, ram_addr, exp_a[k]); end
      ram_ready = 1'b1; tick(); ram_ready = 1'b0;
      checks++; if (done_hart !== exp_h[k] || done_valid !== 1'b1) begin failures++; $display("FAIL rr_rot_done%0d got h=%0d v=%0b exp h=%0d", k, done_hart, done_valid, exp_h[k]); end
      tick();
    end
  endtask

  task automatic test_wrap3();
    logic [1:0]  exp_h [3];
    logic [31:0] exp_a [3];
    exp_h = '{2'd1, 2'd2, 2'd0};
    exp_a = '{32'h7100, 32'h7200, 32'h7000};
    do_reset();
    miss(2'd1, 32'h7100); tick();
    miss(2'd0, 32'h7000); tick();
    miss(2'd2, 32'h7200); tick();
    clear_inputs();
    checks++; if (b_pending !== 3'b111) begin failures++; $display("FAIL wrap_pending got=%b exp=111", b_pending); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (b_ram_req !== 1'b1 || b_ram_addr !== exp_a[k]) begin failures++; $display("FAIL wrap_req%0d got req=%0b addr=%h exp addr=%h", k, b_ram_req, b_ram_addr, exp_a[k]); end
      ram_ready = 1'b1; tick(); ram_ready = 1'b0;
      checks++; if (b_done_hart !== exp_h[k] || b_done_valid !== 1'b1) begin failures++; $display("FAIL wrap_done%0d got h=%0d v=%0b exp h=%0d", k, b_done_hart, b_done_valid, exp_h[k]); end
      tick();
    end
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL wrap_idle got busy=%0b exp=0", b_busy); end
  endtask

  task automatic test_overwrite();
    do_reset();
    miss(2'd0, 32'h3000); tick();
    miss(2'd2, 32'h0100); tick();
    checks++; if (pending !== 4'b0101) begin failures++; $display("FAIL ovw_pending got=%b exp=0101", pending); end
    miss(2'd2, 32'h0200); tick();
    clear_inputs();
    ram_ready = 1'b1; tick(); ram_ready = 1'b0;
    tick();
    checks++; if (ram_req !== 1'b1 || ram_addr !== 32'h0200) begin failures++; $display("FAIL ovw_addr got req=%0b addr=%h exp addr=00000200", ram_req, ram_addr); end
    ram_ready = 1'b1; tick(); ram_ready = 1'b0;
    checks++; if (done_hart !== 2'd2 || done_valid !== 1'b1) begin failures++; $display("FAIL ovw_done got h=%0d v=%0b exp h=2", done_hart, done_valid); end
    tick();
    checks++; if (busy !== 1'b0 || pending !== 4'b0) begin failures++; $display("FAIL ovw_single got busy=%0b pend=%b exp 0 0000", busy, pending); end
  endtask

  task automatic test_flush_inflight();
    do_reset();
    miss(2'd1, 32'h4000); tick();
    clear_inputs();
    flush = 4'b0010; tick(); flush = '0;
    checks++; if (ram_req !== 1'b1 || pending !== 4'b0000) begin failures++; $display("FAIL flush_wait got req=%0b pend=%b exp req=1 pend=0000", ram_req, pending); end
    flush = 4'b0010;
    miss(2'd1, 32'h4100); tick();
    clear_inputs();
    checks++; if (pending !== 4'b0010) begin failures++; $display("FAIL flush_miss_same got pend=%b exp=0010", pending); end
    ram_ready = 1'b1; ram_data = 32'hCAFE_0001; tick(); clear_inputs();
    checks++; if (fill_we !== 1'b1 || done_valid !== 1'b0 || fill_data !== 32'hCAFE_0001) begin failures++; $display("FAIL flush_fill got we=%0b done=%0b data=%h exp we=1 done=0 data=cafe0001", fill_we, done_valid, fill_data); end
    tick();
    checks++; if (ram_req !== 1'b1 || ram_addr !== 32'h4100) begin failures++; $display("FAIL flush_next got req=%0b addr=%h exp addr=00004100", ram_req, ram_addr); end
    ram_ready = 1'b1; tick(); ram_ready = 1'b0;
    checks++; if (done_valid !== 1'b1 || done_hart !== 2'd1) begin failures++; $display("FAIL flush_next_done got v=%0b h=%0d exp v=1 h=1", done_valid, done_hart); end
    tick();
  endtask

  task automatic test_duplicate_race();
    do_reset();
    miss(2'd3, 32'h5004); tick();
    miss(2'd3, 32'h5004); tick();
    clear_inputs();
    checks++; if (pending !== 4'b1000) begin failures++; $display("FAIL dup_pending got=%b exp=1000", pending); end
    miss(2'd3, 32'h5004);
    ram_ready = 1'b1; tick(); clear_inputs();
    checks++; if (done_valid !== 1'b1 || done_hart !== 2'd3) begin failures++; $display("FAIL race_done got v=%0b h=%0d exp v=1 h=3", done_valid, done_hart); end
    tick();
    checks++; if (busy !== 1'b0 || pending !== 4'b0 || ram_req !== 1'b0) begin failures++; $display("FAIL race_dropped got busy=%0b pend=%b req=%0b exp 0 0000 0", busy, pending, ram_req); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    miss(2'd2, 32'h6000); tick();
    clear_inputs();
    checks++; if (ram_req !== 1'b1) begin failures++; $display("FAIL rstmid_pre got req=%0b exp=1", ram_req); end
    nReset = 1'b0;
    #1;
    checks++; if (ram_req !== 1'b0 || busy !== 1'b0 || pending !== 4'b0) begin failures++; $display("FAIL rstmid_async got req=%0b busy=%0b pend=%b exp 0 0 0000", ram_req, busy, pending); end
    @(posedge clk); #1;
    nReset = 1'b1;
    ram_ready = 1'b1; ram_data = 32'hDEAD_BEEF; tick(); clear_inputs();
    checks++; if (fill_we !== 1'b0 || done_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_stray got we=%0b done=%0b busy=%0b exp 0 0 0", fill_we, done_valid, busy); end
    tick();
    checks++; if (fill_we !== 1'b0 || ram_req !== 1'b0) begin failures++; $display("FAIL rstmid_after got we=%0b req=%0b exp 0 0", fill_we, ram_req); end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_round_robin();
    test_wrap3();
    test_overwrite();
    test_flush_inflight();
    test_duplicate_race();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
